// File: rtl/voter_session.sv
// Session-based voting unit: collects one ballot per voter while OPEN, then
// tallies yes votes and reports a one-hot {fail, tie, pass} result.
module voter_session #(
  parameter  int N_VOTERS = 4,
  parameter  int TIMEOUT  = 16,
  localparam int CNT_W    = $clog2(N_VOTERS + 1),
  localparam int TMR_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                close,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted,
  output logic [CNT_W-1:0]    yes_count,
  output logic [3:1]          O,
  output logic                result_valid
);

  typedef enum logic [1:0] {IDLE, OPEN, TALLY, DONE} state_t;

  localparam logic [CNT_W:0] N_EXT       = (CNT_W + 1)'(N_VOTERS);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  state_t              state;
  state_t              next_state;
  logic [N_VOTERS-1:0] ballot;
  logic [TMR_W-1:0]    timer;
  logic [N_VOTERS-1:0] accept;
  logic                session_end;
  logic [CNT_W-1:0]    tally_count;
  logic [CNT_W:0]      twice_yes;
  logic [3:1]          tally_class;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTERS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Only voters that have not yet been accepted this session may vote.
  assign accept      = vote_valid & ~voted;
  assign session_end = close || (&(voted | accept)) || (timer == TIMER_LAST);

  assign tally_count = popcount(ballot);
  assign twice_yes   = {tally_count, 1'b0};

  always_comb begin
    tally_class = 3'b100;
    if (twice_yes > N_EXT)
      tally_class = 3'b001;
    else if (twice_yes == N_EXT)
      tally_class = 3'b010;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = OPEN;
      OPEN:    if (session_end) next_state = TALLY;
      TALLY:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == OPEN) || (state == TALLY);
    result_valid = (state == DONE);
  end

  // Results are captured on the TALLY->DONE edge and then held across IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      voted     <= '0;
      ballot    <= '0;
      timer     <= '0;
      yes_count <= '0;
      O         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            voted  <= '0;
            ballot <= '0;
            timer  <= '0;
          end
        end
        OPEN: begin
          voted  <= voted | accept;
          ballot <= (ballot & ~accept) | (vote_yes & accept);
          timer  <= timer + 1'b1;
        end
        TALLY: begin
          yes_count <= tally_count;
          O         <= tally_class;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voter_session.sv
// Bench for voter_session: a 4-voter and a 5-voter instance share stimulus;
// each session is predicted from ballot masks and checked cycle by cycle.
module tb_voter_session;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        close;
  logic [31:0] vote_valid;
  logic [31:0] vote_yes;

  logic        busy_a, rv_a, busy_b, rv_b;
  logic [3:0]  voted_a;
  logic [4:0]  voted_b;
  logic [2:0]  count_a, count_b;
  logic [3:1]  o_a, o_b;

  bit          sel;
  logic        obs_busy, obs_rv;
  logic [31:0] obs_voted;
  logic [2:0]  obs_count;
  logic [2:0]  obs_o;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] q_valid[$];
  logic [31:0] q_yes[$];
  bit          q_close[$];

  always #5 clk = ~clk;

  voter_session #(.N_VOTERS(4), .TIMEOUT(TIMEOUT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .close(close),
    .vote_valid(vote_valid[3:0]), .vote_yes(vote_yes[3:0]),
    .busy(busy_a), .voted(voted_a), .yes_count(count_a), .O(o_a),
    .result_valid(rv_a)
  );

  voter_session #(.N_VOTERS(5), .TIMEOUT(TIMEOUT)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .close(close),
    .vote_valid(vote_valid[4:0]), .vote_yes(vote_yes[4:0]),
    .busy(busy_b), .voted(voted_b), .yes_count(count_b), .O(o_b),
    .result_valid(rv_b)
  );

  assign obs_busy  = sel ? busy_b : busy_a;
  assign obs_rv    = sel ? rv_b : rv_a;
  assign obs_voted = sel ? {27'b0, voted_b} : {28'b0, voted_a};
  assign obs_count = sel ? count_b : count_a;
  assign obs_o     = sel ? o_b : o_a;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic addStep(input logic [31:0] v, input logic [31:0] y, input bit c);
    q_valid.push_back(v);
    q_yes.push_back(y);
    q_close.push_back(c);
  endtask

  task automatic applyStimulus(input bit s, input bit c, input logic [31:0] v,
                               input logic [31:0] y);
    @(negedge clk);
    start      = s;
    close      = c;
    vote_valid = v;
    vote_yes   = y;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One full session: start, OPEN cycles until the predicted exit, TALLY, DONE, IDLE.
  task automatic runSession(input bit inst, input bit scripted);
    int          nv;
    logic [31:0] mask, m_voted, m_ballot, accept, v, y;
    bit          c, done;
    int          yes;
    logic [2:0]  exp_o;

    sel  = inst;
    nv   = inst ? 5 : 4;
    mask = (32'd1 << nv) - 32'd1;

    applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    @(posedge clk); #1;
    checkOutput("start_busy", obs_busy, 1);
    checkOutput("start_voted", obs_voted, 0);
    checkOutput("start_rv", obs_rv, 0);

    m_voted  = 0;
    m_ballot = 0;
    done     = 1'b0;
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      if (scripted) begin
        if (q_valid.size() > 0) begin
          v = q_valid.pop_front();
          y = q_yes.pop_front();
          c = q_close.pop_front();
        end else begin
          v = 0; y = 0; c = 1'b0;
        end
      end else begin
        v = $urandom & $urandom & $urandom;
        y = $urandom;
        c = ($urandom_range(0, 11) == 0);
      end
      applyStimulus(1'($urandom_range(0, 1)), c, v, y);
      accept   = v & mask & ~m_voted;
      m_voted  = m_voted | accept;
      m_ballot = (m_ballot & ~accept) | (y & accept);
      done     = c || (m_voted == mask) || (k == TIMEOUT - 1);
      @(posedge clk); #1;
      checkOutput("open_voted", obs_voted, m_voted);
      checkOutput("open_busy", obs_busy, 1);
      checkOutput("open_rv", obs_rv, 0);
    end

    yes = $countones(m_ballot);
    if (2 * yes > nv)       exp_o = 3'b001;
    else if (2 * yes == nv) exp_o = 3'b010;
    else                    exp_o = 3'b100;

    // A start while in TALLY must not disturb the session.
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    @(posedge clk); #1;
    checkOutput("done_rv", obs_rv, 1);
    checkOutput("done_busy", obs_busy, 0);
    checkOutput("done_count", obs_count, yes);
    checkOutput("done_o", obs_o, exp_o);
    checkOutput("done_voted", obs_voted, m_voted);

    applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    @(posedge clk); #1;
    checkOutput("idle_rv", obs_rv, 0);
    checkOutput("idle_busy", obs_busy, 0);
    checkOutput("hold_count", obs_count, yes);
    checkOutput("hold_o", obs_o, exp_o);
    checkOutput("hold_voted", obs_voted, m_voted);

    q_valid.delete();
    q_yes.delete();
    q_close.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_rv_a", rv_a, 0);
    checkOutput("rst_o_a", o_a, 0);
    checkOutput("rst_count_a", count_a, 0);
    checkOutput("rst_voted_b", voted_b, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    idleCycles(2);

    // All four vote in one cycle, 0/1/3 yes: auto-close, pass with 3.
    addStep(32'hF, 32'hB, 1'b0);
    runSession(1'b0, 1'b1);
    checkOutput("d34_count", obs_count, 3);
    checkOutput("d34_o", obs_o, 3'b001);

    addStep(32'h3, 32'h3, 1'b0);
    addStep(32'h0, 32'h0, 1'b1);
    runSession(1'b0, 1'b1);
    checkOutput("d35_count", obs_count, 2);
    checkOutput("d35_o", obs_o, 3'b010);

    addStep(32'h0, 32'h0, 1'b1);
    runSession(1'b0, 1'b1);
    checkOutput("d35b_o", obs_o, 3'b100);
    checkOutput("d35b_voted", obs_voted, 0);

    // Repeat votes cannot overwrite a ballot; the vote sent with close counts.
    addStep(32'h4, 32'h4, 1'b0);
    addStep(32'h4, 32'h0, 1'b0);
    addStep(32'h4, 32'h0, 1'b0);
    addStep(32'h1, 32'h1, 1'b1);
    runSession(1'b0, 1'b1);
    checkOutput("d36_count", obs_count, 2);
    checkOutput("d36_o", obs_o, 3'b010);

    addStep(32'h1, 32'h1, 1'b0);
    runSession(1'b0, 1'b1);
    checkOutput("d37_count", obs_count, 1);
    checkOutput("d37_o", obs_o, 3'b100);

    for (int i = 0; i < 20; i++) runSession(1'b0, 1'b0);

    idleCycles(TIMEOUT + 4);
    addStep(32'h07, 32'h07, 1'b1);
    runSession(1'b1, 1'b1);
    checkOutput("d38_pass", obs_o, 3'b001);
    addStep(32'h1F, 32'h03, 1'b0);
    runSession(1'b1, 1'b1);
    checkOutput("d38_fail", obs_o, 3'b100);
    checkOutput("d38_count", obs_count, 2);
    for (int i = 0; i < 12; i++) runSession(1'b1, 1'b0);

    // Mid-session reset abandons the session with no result pulse.
    idleCycles(TIMEOUT + 4);
    sel = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h1, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h2, 32'h2);
    @(posedge clk); #1;
    checkOutput("pre_rst_voted", obs_voted, 32'h3);
    @(negedge clk);
    rst_n      = 1'b0;
    start      = 1'b1;
    close      = 1'b1;
    vote_valid = 32'hF;
    vote_yes   = 32'hF;
    @(posedge clk); #1;
    checkOutput("mid_rst_busy", obs_busy, 0);
    checkOutput("mid_rst_rv", obs_rv, 0);
    checkOutput("mid_rst_voted", obs_voted, 0);
    checkOutput("mid_rst_o", obs_o, 0);
    checkOutput("mid_rst_count", obs_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      checkOutput("post_rst_rv", obs_rv, 0);
      checkOutput("post_rst_busy", obs_busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
